// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, NOP encoding and the
// fetch entry layout consumed by fetch_buffer and the decode stage.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    // All-zero word is what decode treats as a bubble
    localparam logic [31:0] NOP_INST = 32'h0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] inst;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle; slave is the buffer's view, master is the
// fetch/decode side that drives it.
interface fetch_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_W-1:0]        in_pc;
    logic [DATA_W-1:0]        in_inst;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_pc;
    logic [DATA_W-1:0]        out_inst;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// In-order {pc, inst} FIFO between fetch and decode. Define FETCH_BUF_BYPASS_EN
// to forward a push straight to the output when the buffer is empty.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;

    logic            full, empty;
    logic            push_w, pop_w;
    logic            out_vld;
    entry_t          head, out_ent;

    always_comb begin
        full  = (cnt == CW'(DEPTH));
        empty = (cnt == '0);
        head  = mem[rd_ptr];
        // Only entries actually held in storage can be popped
        pop_w = ~empty & bus.out_ready;
`ifdef FETCH_BUF_BYPASS_EN
        out_vld = empty ? (bus.in_valid & ~bus.flush) : 1'b1;
        out_ent = empty ? entry_t'({bus.in_pc, bus.in_inst}) : head;
        // A bypassed word consumed this cycle must not also be stored
        push_w  = bus.in_valid & ~full & ~(empty & ~bus.flush & bus.out_ready);
`else
        out_vld = ~empty;
        out_ent = head;
        push_w  = bus.in_valid & ~full;
`endif
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = out_vld;
    assign bus.out_pc    = out_vld ? out_ent.pc   : '0;
    assign bus.out_inst  = out_vld ? out_ent.inst : DATA_W'(NOP_INST);
    assign bus.count     = cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= '0;
        end else begin
            if (push_w) wr_ptr <= wr_ptr + PW'(1);
            if (pop_w)  rd_ptr <= rd_ptr + PW'(1);
            if (push_w && !pop_w)      cnt <= cnt + CW'(1);
            else if (pop_w && !push_w) cnt <= cnt - CW'(1);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_w && !bus.flush)
            mem[wr_ptr] <= entry_t'({bus.in_pc, bus.in_inst});
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=4); bypass checks only when
// FETCH_BUF_BYPASS_EN is defined.
module tb_fetch_buffer;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_buffer_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) bus ();

    fetch_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
        chk("rst_out_inst",  64'(bus.out_inst),  64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        resetn = 1'b1;

        // first push, latency of one cycle
        drive(1'b1, 32'h100, 32'h2008000A, 1'b0, 1'b0);
`ifndef FETCH_BUF_BYPASS_EN
        chk("no_comb_path", 64'(bus.out_valid), 64'd0);
`endif
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("p1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("p1_out_pc",    64'(bus.out_pc),    64'h100);
        chk("p1_out_inst",  64'(bus.out_inst),  64'h2008000A);
        chk("p1_count",     64'(bus.count),     64'd1);

        // fill to DEPTH, then a fifth push is refused
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 32'hA000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("full_count",    64'(bus.count),    64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 32'h110, 32'hBEEF, 1'b0, 1'b0);
        step();
        chk("fifth_count", 64'(bus.count),  64'd4);
        chk("fifth_head",  64'(bus.out_pc), 64'h100);

        // full with push+pop: only the pop happens
        drive(1'b1, 32'h110, 32'hBEEF, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fpp_count", 64'(bus.count),  64'd3);
        chk("fpp_head",  64'(bus.out_pc), 64'h104);
        chk("fpp_inst",  64'(bus.out_inst), 64'hA001);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("drain1_pc", 64'(bus.out_pc), 64'h108);
        step();
        chk("drain2_pc", 64'(bus.out_pc), 64'h10C);
        chk("drain2_count", 64'(bus.count), 64'd1);
        step();
        chk("drain3_valid", 64'(bus.out_valid), 64'd0);
        chk("drain3_pc",    64'(bus.out_pc),    64'd0);
        chk("drain3_count", 64'(bus.count),     64'd0);

        // three held entries, flush with a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4*i), 32'hC000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        drive(1'b1, 32'h20C, 32'hC003, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_count",    64'(bus.count),     64'd0);
        chk("flush_valid",    64'(bus.out_valid), 64'd0);
        chk("flush_inst",     64'(bus.out_inst),  64'd0);
        chk("flush_in_ready", 64'(bus.in_ready),  64'd1);

        // one entry primed, then ten push/pop pairs across the pointer wrap
        drive(1'b1, 32'h300, 32'h300 ^ 32'hA5A50000, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h304 + 32'(4*i), (32'h304 + 32'(4*i)) ^ 32'hA5A50000, 1'b1, 1'b0);
            chk($sformatf("wrap_pc_%0d", i), 64'(bus.out_pc), 64'(32'h300 + 32'(4*i)));
            chk($sformatf("wrap_inst_%0d", i), 64'(bus.out_inst),
                64'((32'h300 + 32'(4*i)) ^ 32'hA5A50000));
            step();
            chk($sformatf("wrap_cnt_%0d", i), 64'(bus.count), 64'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("wrap_last_pc", 64'(bus.out_pc), 64'h328);

        // asynchronous reset mid-operation, no clock edge needed
        drive(1'b1, 32'h500, 32'h5000, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pre_arst_count", 64'(bus.count), 64'd2);
        resetn = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count),     64'd0);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_pc",    64'(bus.out_pc),    64'd0);
        chk("arst_ready", 64'(bus.in_ready),  64'd1);
        step();
        resetn = 1'b1;

`ifdef FETCH_BUF_BYPASS_EN
        drive(1'b1, 32'h400, 32'h4444, 1'b1, 1'b0);
        chk("byp_valid", 64'(bus.out_valid), 64'd1);
        chk("byp_pc",    64'(bus.out_pc),    64'h400);
        chk("byp_inst",  64'(bus.out_inst),  64'h4444);
        step();
        chk("byp_count", 64'(bus.count), 64'd0);
        drive(1'b1, 32'h404, 32'h4445, 1'b1, 1'b1);
        chk("byp_flush_valid", 64'(bus.out_valid), 64'd0);
        step();
        drive(1'b1, 32'h408, 32'h4446, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("byp_store_count", 64'(bus.count),  64'd1);
        chk("byp_store_pc",    64'(bus.out_pc), 64'h408);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32: PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: number of entries, a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: discard all held entries (branch, jump or exception redirect).
REQ-007 SHALL have port in_valid, input, 1 bit: fetch presents a valid pc/inst pair.
REQ-008 SHALL have port in_ready, output, 1 bit: the buffer accepts the pair this cycle.
REQ-009 SHALL have port in_pc, input, ADDR_W bits: PC of the incoming instruction.
REQ-010 SHALL have port in_inst, input, DATA_W bits: incoming instruction word.
REQ-011 SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-012 SHALL have port out_ready, input, 1 bit: decode consumes the head entry (deasserted on hazard or execute stall).
REQ-013 SHALL have port out_pc, output, ADDR_W bits: PC of the head entry.
REQ-014 SHALL have port out_inst, output, DATA_W bits: instruction word of the head entry.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-016 SHALL implement an in-order FIFO of {pc, inst} entries; push occurs when in_valid and in_ready, pop when out_valid and out_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH) combinationally; no push when full, even with a simultaneous pop.
REQ-018 SHALL drive out_valid = (count != 0) when FETCH_BUF_BYPASS_EN is undefined; push-to-out_valid latency is 1 cycle.
REQ-019 SHALL drive out_pc and out_inst to all-zero whenever out_valid is low, so decode sees a NOP bubble.
REQ-020 SHALL, on a simultaneous push and pop while non-empty and non-full, keep count unchanged and advance both pointers.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-022 SHALL, with flush high at a rising edge, set count to 0 and equalise the pointers; the push and pop of that cycle are ignored.
REQ-023 SHALL keep out_valid low in the cycle after a flush unless FETCH_BUF_BYPASS_EN bypasses a new push.
REQ-024 SHALL hold count within the range 0..DEPTH at all times.

Reset
REQ-025 SHALL, while resetn is low, asynchronously clear the pointers and count, so in_ready=1, out_valid=0, out_pc=0, out_inst=0 and count=0.
REQ-026 SHALL, when reset asserts mid-operation, discard all entries immediately without waiting for a clock edge.
REQ-027 SHALL NOT reset the storage array; only the valid and occupancy state is reset.

Configuration
REQ-028 SHALL, with FETCH_BUF_BYPASS_EN defined and count==0, present in_valid/in_pc/in_inst combinationally on out_valid/out_pc/out_inst.
REQ-029 SHALL, in that bypass case, not store the entry if out_ready is also high and flush is low; otherwise it SHALL store the entry normally.
REQ-030 SHALL, with FETCH_BUF_BYPASS_EN defined and flush high, still suppress the bypass: out_valid=0.
REQ-031 SHALL, without FETCH_BUF_BYPASS_EN, have no combinational path from any in_* port to any out_* port.

Structure
REQ-032 SHALL place the default widths and the NOP encoding constant (32'h0) in the shared package cpu_pkg.
REQ-033 SHALL define the entry typedef fetch_entry_t {pc, inst} in cpu_pkg, for reuse by the decode stage.
REQ-034 SHALL be a single module with no sub-module; the storage is an inferred register array.

Verification
REQ-035 SHALL cover: reset, then push pc=0x100/inst=0x2008000A -> next cycle out_valid=1, out_pc=0x100, out_inst=0x2008000A, count=1.
REQ-036 SHALL cover: DEPTH=4, four pushes with out_ready=0 -> count=4, in_ready=0; a fifth in_valid is not accepted.
REQ-037 SHALL cover: full with push and pop in the same cycle -> only the pop occurs, count=3, and order is preserved.
REQ-038 SHALL cover: three entries held plus flush with in_valid=1 -> next cycle count=0, out_valid=0, out_inst=0.
REQ-039 SHALL cover: ten push/pop pairs crossing the wrap point -> the out_pc sequence equals the in_pc sequence.
REQ-040 SHALL cover, with FETCH_BUF_BYPASS_EN: empty buffer with in_valid=1 and out_ready=1 -> same-cycle out_valid=1 and count stays 0.
